// File: rtl/swc_pkg.sv
// swc_pkg: shared opcodes, global state and continuous-mode encodings for swc_multi.
package swc_pkg;
    typedef enum logic [1:0] {S_RESET, S_READY, S_ERROR} state_e;
    typedef enum logic [1:0] {M_NONE, M_UP, M_DOWN} mode_e;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDS = 4'h1;
    localparam logic [3:0] OP_COU = 4'h4;
    localparam logic [3:0] OP_COD = 4'h5;
    localparam logic [3:0] OP_CCU = 4'h6;
    localparam logic [3:0] OP_CCD = 4'h7;
    localparam logic [3:0] OP_CCS = 4'h8;
    localparam logic [3:0] OP_CLR = 4'h9;
    localparam logic [3:0] OP_SPD = 4'hA;
    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_NOP, OP_LDS, OP_COU, OP_COD, OP_CCU, OP_CCD, OP_CCS, OP_CLR, OP_SPD};
    endfunction
endpackage

// File: rtl/swc_channel.sv
// swc_channel: one counter with its continuous mode, divider and divider phase.
module swc_channel
    import swc_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [3:0]       op,
    input  logic [7:0]       imm,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_nxt
);
    mode_e            mode, mode_nxt;
    logic [7:0]       div, div_nxt, phase, phase_nxt;
    logic [WIDTH-1:0] inc, dec, stepped;
    assign inc = cnt + WIDTH'(1);
    assign dec = cnt - WIDTH'(1);
    assign stepped = mode == M_UP ? inc : dec;
    // continuous step first; an instruction that touches the counter then overrides it
    always_comb begin
        cnt_nxt = cnt;
        mode_nxt = mode;
        div_nxt = div;
        phase_nxt = phase;
        if (mode != M_NONE) begin
            phase_nxt = phase == '0 ? div : phase - 8'd1;
            if (phase == '0) begin
                cnt_nxt = stepped;
                mode_nxt = stepped == '0 ? M_NONE : mode;
            end
        end
        if (en) begin
            case (op)
                OP_LDS: begin cnt_nxt = WIDTH'({cnt, imm}); mode_nxt = M_NONE; end
                OP_COU: begin cnt_nxt = inc; mode_nxt = M_NONE; end
                OP_COD: begin cnt_nxt = dec; mode_nxt = M_NONE; end
                OP_CCU: begin cnt_nxt = inc; mode_nxt = inc == '0 ? M_NONE : M_UP; phase_nxt = div; end
                OP_CCD: begin cnt_nxt = dec; mode_nxt = dec == '0 ? M_NONE : M_DOWN; phase_nxt = div; end
                OP_CCS: begin cnt_nxt = cnt; mode_nxt = M_NONE; end
                OP_CLR: begin cnt_nxt = '0; mode_nxt = M_NONE; end
                OP_SPD: div_nxt = imm;
                default: ;
            endcase
        end
        if (clear) begin
            cnt_nxt = '0;
            mode_nxt = M_NONE;
            div_nxt = '0;
            phase_nxt = '0;
        end
    end
    always_ff @(posedge clock) begin
        cnt <= cnt_nxt;
        mode <= mode_nxt;
        div <= div_nxt;
        phase <= phase_nxt;
    end
endmodule

// File: rtl/swc_multi.sv
// swc_multi: instruction decode, channel select and global Reset/Ready/Error state
// over CHANNELS independent swc_channel counters.
module swc_multi
    import swc_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CHANNELS = 4,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [11+CW:0]            inst,
    input  logic                      inst_en,
    output logic [CHANNELS*WIDTH-1:0] counter,
    output logic [CHANNELS-1:0]       ready,
    output logic                      error
);
    state_e              state, state_nxt;
    logic [CW-1:0]       sel;
    logic [3:0]          op;
    logic [7:0]          imm;
    logic                bad;
    logic [CHANNELS-1:0] zero;
    logic [WIDTH-1:0]    cnt_nxt [CHANNELS];
    assign sel = inst[11+CW:12];
    assign op = inst[11:8];
    assign imm = inst[7:0];
    assign bad = inst_en && (!op_legal(op) || int'(sel) >= CHANNELS);
    always_comb begin
        state_nxt = state;
        if (state == S_RESET) state_nxt = S_READY;
        else if (state == S_READY && bad) state_nxt = S_ERROR;
        if (reset) state_nxt = S_RESET;
    end
    // leaving Ready (reset or error) clears every channel on the same edge
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        swc_channel #(.WIDTH(WIDTH)) u_ch (
            .clock(clock),
            .clear(state_nxt != S_READY),
            .en(inst_en && state == S_READY && int'(sel) == k),
            .op(op),
            .imm(imm),
            .cnt(counter[k*WIDTH +: WIDTH]),
            .cnt_nxt(cnt_nxt[k])
        );
        assign zero[k] = cnt_nxt[k] == '0;
    end
    always_ff @(posedge clock) begin
        state <= state_nxt;
        ready <= state_nxt == S_READY ? zero : '0;
        error <= state_nxt == S_ERROR;
    end
endmodule

// File: tb/tb_swc_multi.sv
// tb_swc_multi: directed and random stimulus against an absolute-time reference model.
module tb_swc_multi;
    localparam int W = 24;
    localparam int CH = 5;
    localparam int CW = 3;
    localparam longint MASK = (64'd1 << W) - 1;

    logic clock = 0;
    logic reset = 1;
    logic [11+CW:0] inst = '0;
    logic inst_en = 0;
    logic [CH*W-1:0] counter;
    logic [CH-1:0] ready;
    logic error;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int m_st = 0;
    longint m_cnt[CH];
    int m_mode[CH];
    int m_div[CH];
    int m_next[CH];
    int ops[9] = '{0, 1, 4, 5, 6, 7, 8, 9, 10};

    swc_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
        .counter(counter), .ready(ready), .error(error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s got %0h want %0h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int k = 0; k < CH; k++) begin
            m_cnt[k] = 0; m_mode[k] = 0; m_div[k] = 0; m_next[k] = 0;
        end
    endtask

    // model of one clock edge: mode 0 none, 1 up, 2 down; m_next is the cycle of the next step
    task automatic model_edge(input bit rst, input bit en, input int op, input int ch, input int imm);
        longint pre;
        cyc++;
        if (rst) begin m_st = 0; clear_model(); return; end
        if (m_st == 0) begin m_st = 1; return; end
        if (m_st == 2) return;
        if (en && (!(op inside {0, 1, 4, 5, 6, 7, 8, 9, 10}) || ch >= CH)) begin
            m_st = 2; clear_model(); return;
        end
        for (int k = 0; k < CH; k++) begin
            pre = m_cnt[k];
            if (m_mode[k] != 0 && cyc == m_next[k]) begin
                m_cnt[k] = (m_mode[k] == 1 ? pre + 1 : pre + MASK) & MASK;
                if (m_cnt[k] == 0) m_mode[k] = 0;
                m_next[k] = cyc + m_div[k] + 1;
            end
            if (en && ch == k) begin
                case (op)
                    1: begin m_cnt[k] = ((pre << 8) | imm) & MASK; m_mode[k] = 0; end
                    4: begin m_cnt[k] = (pre + 1) & MASK; m_mode[k] = 0; end
                    5: begin m_cnt[k] = (pre + MASK) & MASK; m_mode[k] = 0; end
                    6, 7: begin
                        m_cnt[k] = (op == 6 ? pre + 1 : pre + MASK) & MASK;
                        m_mode[k] = m_cnt[k] == 0 ? 0 : op - 5;
                        m_next[k] = cyc + m_div[k] + 1;
                    end
                    8: begin m_cnt[k] = pre; m_mode[k] = 0; end
                    9: begin m_cnt[k] = 0; m_mode[k] = 0; end
                    10: m_div[k] = imm;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input int op, input int ch, input int imm);
        logic [CH*W-1:0] ec;
        logic [CH-1:0] er;
        reset = rst;
        inst_en = en;
        inst = {CW'(ch), 4'(op), 8'(imm)};
        @(posedge clock);
        model_edge(rst, en, op, ch, imm);
        #1;
        for (int k = 0; k < CH; k++) begin
            ec[k*W +: W] = W'(m_cnt[k]);
            er[k] = m_st == 1 && m_cnt[k] == 0;
        end
        check("counter", counter, ec);
        check("ready", ready, er);
        check("error", error, m_st == 2);
    endtask

    function automatic logic [W-1:0] chv(input int k);
        return counter[k*W +: W];
    endfunction

    initial begin
        int op;
        int ch;
        clear_model();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_counter", counter, '0);
        check("rst_ready", ready, '0);
        check("rst_error", error, 1'b0);
        step(0, 0, 0, 0, 0);
        check("release_ready", ready, 5'h1F);
        step(0, 1, 1, 2, 'h12);
        step(0, 1, 1, 2, 'h34);
        step(0, 1, 1, 2, 'h56);
        check("lds_ch2", chv(2), 24'h123456);
        check("lds_ready", ready, 5'b11011);
        check("lds_others", {chv(0), chv(1), chv(3), chv(4)}, '0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 3);
        step(0, 1, 7, 0, 0);
        check("ccd_2", chv(0), 24'd2);
        step(0, 0, 0, 0, 0);
        check("ccd_1", chv(0), 24'd1);
        step(0, 0, 0, 0, 0);
        check("ccd_0", chv(0), 24'd0);
        check("ccd_ready0", ready[0], 1'b1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("ccd_hold", chv(0), 24'd0);
        step(0, 1, 10, 1, 3);
        step(0, 1, 1, 1, 'hFF);
        step(0, 1, 1, 1, 'hFF);
        step(0, 1, 1, 1, 'hFD);
        step(0, 1, 6, 1, 0);
        check("ccu_c0", chv(1), 24'hFFFFFE);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 3) check("ccu_c3", chv(1), 24'hFFFFFE);
            if (i == 4) check("ccu_c4", chv(1), 24'hFFFFFF);
            if (i == 8) check("ccu_c8", chv(1), 24'h0);
            if (i == 12) check("ccu_stop", chv(1), 24'h0);
        end
        step(0, 1, 6, 0, 0);
        step(0, 1, 6, 3, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 4, 3, 0);
        check("cou_ch3", chv(3), 24'd4);
        check("cou_ch0", chv(0), 24'd5);
        step(0, 0, 0, 0, 0);
        check("cou_ch3_hold", chv(3), 24'd4);
        check("cou_ch0_run", chv(0), 24'd6);
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 8)];
            ch = $urandom_range(0, CH - 1);
            step(0, $urandom_range(0, 4) != 0, op, ch,
                 op == 10 ? $urandom_range(0, 3) : $urandom_range(0, 255));
        end
        step(0, 1, 'hB, 0, 0);
        check("illegal_error", error, 1'b1);
        check("illegal_counter", counter, '0);
        step(0, 1, 1, 0, 'h55);
        check("error_ignores", counter, '0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("recover_error", error, 1'b0);
        check("recover_ready", ready, 5'h1F);
        step(0, 1, 1, 5, 'h11);
        check("badch_error", error, 1'b1);
        check("badch_ready", ready, '0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 4, 'h10);
        step(0, 1, 7, 4, 0);
        check("ccd_run", chv(4), 24'h0F);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("abort_cnt", chv(4), 24'h0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        check("abort_hold", chv(4), 24'h0);
        check("abort_ready", ready, 5'h1F);
        inst_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
